cnt161_seq_ctrl: RTL and testbench

Synchronous sequencer for a 74LS161-style 4-bit counter datapath. It replaces the asynchronous NAND-feedback clear with a clean synchronous modulus reload.
- Generates the counter's enable (CEP/CET), parallel-load (PE_n) and clear (MR_n) controls from start/pause and clear buttons.
- Divides the board clock internally to produce the count rate.
- Reports state and terminal-count so the hex/7-seg display path can show status alongside Q.

---
 rtl/cnt161_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_cnt161_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt161_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cnt161_seq_ctrl
//
// Synchronous sequencer for a 74LS161-style 4-bit counter datapath. Drives the
// counter's enable, parallel-load and clear controls from two push buttons.
// The counter reloads synchronously when Q reaches mod_top. This replaces the
// classic asynchronous NAND-feedback clear.
//
// Parameters:
//   DIV          CP cycles per count tick (>= 2)
//   SYNC_STAGES  button synchronizer depth (>= 2)
//
// Ports:
//   CP         in   system clock, shared with the counter datapath
//   CR         in   synchronous active-high reset
//   btn_start  in   async level; a rising edge toggles start/pause
//   btn_clr    in   async level; a rising edge clears
//   preset[3:0]  in   reload value, wired straight to counter D3..D0
//   mod_top[3:0] in   terminal value; Q == mod_top on a tick triggers reload
//   q[3:0]       in   counter Q3..Q0 feedback
//   cnt_en     out  CEP/CET, active-high
//   load_n     out  PE_n, active-low
//   clr_n      out  MR_n, active-low (synchronous clear on the counter)
//   tc_pulse   out  one CP cycle per reload
//   state[2:0] out  FSM state code
//
// Build option:
//   CNT161_SEQ_ONESHOT_EN  when defined, a reload in RUN stops in DONE
//                          instead of free-running.
// -----------------------------------------------------------------------------
module cnt161_seq_ctrl #(
  parameter int unsigned DIV         = 50000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       btn_start,
  input  logic       btn_clr,
  input  logic [3:0] preset,
  input  logic [3:0] mod_top,
  input  logic [3:0] q,
  output logic       cnt_en,
  output logic       load_n,
  output logic       clr_n,
  output logic       tc_pulse,
  output logic [2:0] state
);

  localparam int unsigned    PW        = $clog2(DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       presc_q, presc_d;

  logic [SYNC_STAGES-1:0] start_sync_q, clr_sync_q;
  logic                   start_hist_q, clr_hist_q;
  logic                   start_pulse_q, clr_pulse_q;

  logic tick, at_top, reload;

  // preset goes directly to the counter's D inputs; the controller never
  // needs its value.
  logic unused_preset;
  assign unused_preset = ^preset;

  // ---------------------------------------------------------------------------
  // Button synchronizers and rising-edge detectors. The edge pulse is
  // registered, so the FSM reacts SYNC_STAGES+1 edges after the first
  // sampling edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CP) begin
    if (CR) begin
      // NOTE: the synchronizer and history flops are reset too, otherwise a
      // stale '0' history could fake a rising edge right after reset.
      start_sync_q  <= '0;
      clr_sync_q    <= '0;
      start_hist_q  <= 1'b0;
      clr_hist_q    <= 1'b0;
      start_pulse_q <= 1'b0;
      clr_pulse_q   <= 1'b0;
    end else begin
      start_sync_q  <= {start_sync_q[SYNC_STAGES-2:0], btn_start};
      clr_sync_q    <= {clr_sync_q[SYNC_STAGES-2:0], btn_clr};
      start_hist_q  <= start_sync_q[SYNC_STAGES-1];
      clr_hist_q    <= clr_sync_q[SYNC_STAGES-1];
      start_pulse_q <= start_sync_q[SYNC_STAGES-1] & ~start_hist_q;
      clr_pulse_q   <= clr_sync_q[SYNC_STAGES-1] & ~clr_hist_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Tick / reload decode. A clear pulse in the same cycle cancels both
  // count and reload, so the counter is left alone while clear takes over.
  // ---------------------------------------------------------------------------
  assign tick   = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
  assign at_top = (q == mod_top);
  assign reload = tick && at_top && !clr_pulse_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CP) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    if (CR) state_q <= ST_CLEAR;
    else    state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. Clear has priority over everything else.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would infer a latch.
    state_d = state_q;
    if (clr_pulse_q) begin
      state_d = ST_CLEAR;
    end else begin
      unique case (state_q)
        ST_CLEAR: state_d = ST_IDLE;
        ST_IDLE:  if (start_pulse_q) state_d = ST_LOAD;
        ST_LOAD:  state_d = ST_RUN;
        ST_RUN: begin
`ifdef CNT161_SEQ_ONESHOT_EN
          if (reload)             state_d = ST_DONE;
          else if (start_pulse_q) state_d = ST_PAUSE;
`else
          if (start_pulse_q)      state_d = ST_PAUSE;
`endif
        end
        ST_PAUSE: if (start_pulse_q) state_d = ST_RUN;
`ifdef CNT161_SEQ_ONESHOT_EN
        ST_DONE:  if (start_pulse_q) state_d = ST_LOAD;
`endif
        default:  state_d = ST_CLEAR;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler: runs only in RUN, frozen in PAUSE (so resume keeps the phase),
  // zero everywhere else, which also clears it on LOAD -> RUN.
  // ---------------------------------------------------------------------------
  always_comb begin
    presc_d = '0;
    if (state_q == ST_RUN) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    end else if (state_q == ST_PAUSE) begin
      presc_d = presc_q;
    end
  end

  always_ff @(posedge CP) begin
    if (CR) presc_q <= '0;
    else    presc_q <= presc_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode. cnt_en and a reload are mutually exclusive because
  // they require opposite values of at_top.
  // ---------------------------------------------------------------------------
  always_comb begin
    clr_n    = (state_q != ST_CLEAR);
    load_n   = !((state_q == ST_LOAD) || reload);
    cnt_en   = tick && !at_top && !clr_pulse_q;
    tc_pulse = reload;
    state    = state_q;
  end

endmodule

// File: tb/tb_cnt161_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cnt161_seq_ctrl
//
// Bench for cnt161_seq_ctrl with DIV=4 and SYNC_STAGES=2. A 74161-style
// counter driven by the DUT's controls closes the Q feedback loop. A
// behavioural reference model is built from the sequencer's rules. It
// predicts state, outputs and Q for every cycle.
// -----------------------------------------------------------------------------
module tb_cnt161_seq_ctrl;

  localparam int DIV = 4;
  localparam int SS  = 2;

  logic       CP = 1'b0;
  logic       CR;
  logic       btn_start, btn_clr;
  logic [3:0] preset, mod_top;
  logic [3:0] q = 4'd0;
  logic       cnt_en, load_n, clr_n, tc_pulse;
  logic [2:0] state;

  cnt161_seq_ctrl #(.DIV(DIV), .SYNC_STAGES(SS)) dut (
    .CP        (CP),
    .CR        (CR),
    .btn_start (btn_start),
    .btn_clr   (btn_clr),
    .preset    (preset),
    .mod_top   (mod_top),
    .q         (q),
    .cnt_en    (cnt_en),
    .load_n    (load_n),
    .clr_n     (clr_n),
    .tc_pulse  (tc_pulse),
    .state     (state)
  );

  always #5 CP = ~CP;

  // 74161-style datapath with synchronous clear.
  always_ff @(posedge CP) begin
    if (!clr_n)      q <= 4'd0;
    else if (!load_n) q <= preset;
    else if (cnt_en)  q <= q + 4'd1;
  end

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  int       m_state, m_presc, m_q;
  bit [7:0] hs, hc;        // sampled button history, bit 0 = most recent edge
  int       cyc;
  int       tc_q[$];
  int       tc_cnt, en_cnt;
  int       checks, errors;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One CP cycle: compare outputs against the model, then advance both.
  task automatic cycle();
    bit sp, cp, tk, top, e_rel, e_en, e_ld_n, e_clr_n;
    int ns, np, nq;
    #1;
    sp      = hs[SS] & ~hs[SS+1];
    cp      = hc[SS] & ~hc[SS+1];
    tk      = (m_state == 3) && (m_presc == DIV - 1);
    top     = (m_q == int'(mod_top));
    e_rel   = tk && top && !cp;
    e_en    = tk && !top && !cp;
    e_ld_n  = !((m_state == 2) || e_rel);
    e_clr_n = (m_state != 0);

    check("state",    32'(state),    m_state);
    check("clr_n",    32'(clr_n),    int'(e_clr_n));
    check("load_n",   32'(load_n),   int'(e_ld_n));
    check("cnt_en",   32'(cnt_en),   int'(e_en));
    check("tc_pulse", 32'(tc_pulse), int'(e_rel));
    check("q",        32'(q),        m_q);

    if (tc_pulse === 1'b1) begin tc_q.push_back(cyc); tc_cnt++; end
    if (cnt_en === 1'b1) en_cnt++;

    if (CR || cp) ns = 0;
    else begin
      case (m_state)
        0: ns = 1;
        1: ns = sp ? 2 : 1;
        2: ns = 3;
`ifdef CNT161_SEQ_ONESHOT_EN
        3: ns = e_rel ? 5 : (sp ? 4 : 3);
        5: ns = sp ? 2 : 5;
`else
        3: ns = sp ? 4 : 3;
`endif
        4: ns = sp ? 3 : 4;
        default: ns = 0;
      endcase
    end
    if (CR)                np = 0;
    else if (m_state == 3) np = (m_presc + 1) % DIV;
    else if (m_state == 4) np = m_presc;
    else                   np = 0;
    if (!e_clr_n)     nq = 0;
    else if (!e_ld_n) nq = int'(preset);
    else if (e_en)    nq = (m_q + 1) % 16;
    else              nq = m_q;

    @(posedge CP);
    m_state = ns;
    m_presc = np;
    m_q     = nq;
    if (CR) begin
      hs = '0;
      hc = '0;
    end else begin
      hs = {hs[6:0], btn_start};
      hc = {hc[6:0], btn_clr};
    end
    cyc++;
    @(negedge CP);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press_start(input int hold);
    btn_start = 1'b1;
    run(hold);
    btn_start = 1'b0;
    run(4);
  endtask

  // Run until the DUT reports the wanted state; an expired budget is a failure.
  task automatic wait_state(input int want, input int budget, input string tag);
    int n = 0;
    while (state !== 3'(want) && n < budget) begin cycle(); n++; end
    check(tag, 32'(state), want);
  endtask

  initial begin
    int saw_bad, saw_clear, q_hold, found;
    checks = 0; errors = 0; cyc = 0; tc_cnt = 0; en_cnt = 0;
    CR = 1'b1; btn_start = 1'b0; btn_clr = 1'b0;
    preset = 4'd0; mod_top = 4'd0;

    // First edge brings the DUT out of X; model starts from reset values.
    @(posedge CP);
    @(negedge CP);
    m_state = 0; m_presc = 0; m_q = 0; hs = '0; hc = '0;

    // 1. Reset: 3 cycles of CR, then CLEAR for one more cycle, then IDLE.
    run(2);
    CR = 1'b0;
    check("reset_clr_n_after", 32'(clr_n), 0);
    run(1);
    check("reset_to_idle", 32'(state), 1);
    run(3);

    // 2. preset=3, mod_top=9: 7 ticks per reload = 28 CP cycles.
    preset = 4'd3; mod_top = 4'd9;
    press_start(1);
    tc_q.delete();
    run(100);
    check("tc_period_3_9", (tc_q.size() >= 2) ? 32'(tc_q[1] - tc_q[0]) : 32'd0, 28);

    // 3. preset=12, mod_top=2: wraps 15->0, still 7 ticks per reload.
    preset = 4'd12; mod_top = 4'd2;
    tc_q.delete();
    run(150);
    check("tc_period_12_2", (tc_q.size() >= 2) ? 32'(tc_q[1] - tc_q[0]) : 32'd0, 28);

    // 4. Pause at Q=6, hold 40 cycles, then resume.
    preset = 4'd3; mod_top = 4'd9;
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      if (q === 4'd6) found = 1;
      else cycle();
    end
    check("reach_q6", 32'(found), 1);
    press_start(2);
    wait_state(4, 20, "enter_pause");
    q_hold = int'(q);
    en_cnt = 0;
    run(40);
    check("pause_no_cnt_en", 32'(en_cnt), 0);
    check("pause_q_frozen", 32'(q), q_hold);
    press_start(1);
    wait_state(3, 20, "resume_run");
    run(30);

    // CR asserted mid-RUN forces CLEAR on the next edge.
    CR = 1'b1;
    run(1);
    CR = 1'b0;
    check("cr_mid_run_clear", 32'(state), 0);
    run(4);

    // preset == mod_top: holds and reloads on every tick.
    preset = 4'd5; mod_top = 4'd5;
    press_start(1);
    wait_state(3, 20, "eq_run");
    tc_cnt = 0;
    run(40);
    check("eq_tc_every_tick", 32'(tc_cnt), 10);
    check("eq_q_hold", 32'(q), 5);

    // 5. clr and start rise together in RUN: clear wins, no LOAD/PAUSE.
    btn_clr = 1'b1; btn_start = 1'b1;
    run(3);
    btn_clr = 1'b0; btn_start = 1'b0;
    run(1);
    saw_bad = 0; saw_clear = 0;
    for (int i = 0; i < 10; i++) begin
      if (state === 3'd2 || state === 3'd4) saw_bad++;
      if (state === 3'd0) saw_clear++;
      cycle();
    end
    check("clr_start_no_load_pause", 32'(saw_bad), 0);
    check("clr_start_one_clear", 32'(saw_clear), 1);
    check("clr_start_idle", 32'(state), 1);

`ifdef CNT161_SEQ_ONESHOT_EN
    // 6. One-shot: 0,1,2 then reload into DONE, silent until re-armed.
    preset = 4'd0; mod_top = 4'd2;
    press_start(1);
    wait_state(5, 60, "oneshot_done");
    check("oneshot_q_preset", 32'(q), 0);
    en_cnt = 0;
    run(50);
    check("oneshot_quiet", 32'(en_cnt), 0);
    press_start(1);
    wait_state(3, 20, "oneshot_rearm");
    run(10);
`endif

    // Randomized phase: button toggles, modulus changes, occasional reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 59) == 0) btn_clr = ~btn_clr;
      if ($urandom_range(0, 39) == 0) preset  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) mod_top = 4'($urandom_range(0, 15));
      CR = ($urandom_range(0, 149) == 0);
      cycle();
    end
    CR = 1'b0;
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
